// File: rtl/collision_pkg.sv
// Shared FSM encoding and default geometry/timing for the collision monitor.
package collision_pkg;

    typedef enum logic [2:0] {
        ARMED,
        HIT,
        GRACE,
        WAIT_CLEAR,
        HALTED
    } state_t;

    localparam int DEF_PLAYER_Y_TOP  = 200;
    localparam int DEF_PLAYER_Y_BOT  = 219;
    localparam int DEF_OBST_H        = 16;
    localparam int DEF_INVULN_CYCLES = 50_000_000;
    localparam int CNT_W             = 26;

endpackage

// File: rtl/obstacle_overlap.sv
// Combinational overlap test of one obstacle slot against the player sprite.
module obstacle_overlap
    import collision_pkg::*;
#(
    parameter int PLAYER_Y_TOP = DEF_PLAYER_Y_TOP,
    parameter int PLAYER_Y_BOT = DEF_PLAYER_Y_BOT,
    parameter int OBST_H       = DEF_OBST_H
) (
    input  logic       valid,
    input  logic [1:0] lane,
    input  logic [1:0] player_lane,
    input  logic [7:0] y,
    output logic       overlap
);

    logic [8:0] y_ext;
    logic [8:0] y_end;

    // 9-bit sum so obstacles near row 255 never wrap into the sprite
    assign y_ext   = {1'b0, y};
    assign y_end   = y_ext + 9'(OBST_H);
    assign overlap = valid && (lane == player_lane)
                  && (y_end > 9'(PLAYER_Y_TOP))
                  && (y_ext <= 9'(PLAYER_Y_BOT));

endmodule

// File: rtl/collision_monitor.sv
// Registers per-slot overlap, then drives hit pulse, grace period and hit counting.
module collision_monitor
    import collision_pkg::*;
#(
    parameter int NUM_OBS       = 4,
    parameter int PLAYER_Y_TOP  = DEF_PLAYER_Y_TOP,
    parameter int PLAYER_Y_BOT  = DEF_PLAYER_Y_BOT,
    parameter int OBST_H        = DEF_OBST_H,
    parameter int INVULN_CYCLES = DEF_INVULN_CYCLES
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [1:0]           player_lane,
    input  logic [NUM_OBS-1:0]   obs_valid,
    input  logic [2*NUM_OBS-1:0] obs_lane,
    input  logic [8*NUM_OBS-1:0] obs_y,
    input  logic                 game_over,
    input  logic                 clear_score,
    output logic                 collision,
    output logic                 invuln,
    output logic [1:0]           hit_lane,
    output logic [7:0]           hit_count
);

    localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(INVULN_CYCLES - 1);

    logic [NUM_OBS-1:0] slot_ovl;
    logic               any_ovl;
    logic [1:0]         first_lane;
    logic               overlap_q;
    logic [1:0]         lane_q;
    logic [CNT_W-1:0]   counter;
    state_t             state;

    for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
        obstacle_overlap #(
            .PLAYER_Y_TOP(PLAYER_Y_TOP),
            .PLAYER_Y_BOT(PLAYER_Y_BOT),
            .OBST_H      (OBST_H)
        ) u_ovl (
            .valid      (obs_valid[g]),
            .lane       (obs_lane[2*g +: 2]),
            .player_lane(player_lane),
            .y          (obs_y[8*g +: 8]),
            .overlap    (slot_ovl[g])
        );
    end

    // Lowest-index overlapping slot supplies the reported lane
    always_comb begin
        any_ovl    = 1'b0;
        first_lane = '0;
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            if (slot_ovl[i] && !any_ovl) begin
                any_ovl    = 1'b1;
                first_lane = obs_lane[2*i +: 2];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            overlap_q <= 1'b0;
            lane_q    <= '0;
        end else begin
            overlap_q <= any_ovl;
            lane_q    <= first_lane;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ARMED;
            counter   <= '0;
            hit_count <= '0;
            hit_lane  <= '0;
            collision <= 1'b0;
            invuln    <= 1'b0;
        end else begin
            collision <= 1'b0;
            if (clear_score) begin
                state     <= ARMED;
                counter   <= '0;
                hit_count <= '0;
                hit_lane  <= '0;
                invuln    <= 1'b0;
            end else begin
                case (state)
                    ARMED: begin
                        if (game_over) begin
                            state  <= HALTED;
                            invuln <= 1'b0;
                        end else if (overlap_q) begin
                            state     <= HIT;
                            hit_lane  <= lane_q;
                            collision <= 1'b1;
                            invuln    <= 1'b1;
                        end
                    end
                    HIT: begin
                        state   <= GRACE;
                        counter <= GRACE_LOAD;
                        invuln  <= 1'b1;
                        if (hit_count != '1)
                            hit_count <= hit_count + 8'd1;
                    end
                    GRACE: begin
                        if (game_over) begin
                            state  <= HALTED;
                            invuln <= 1'b0;
                        end else if (counter == '0) begin
                            state  <= overlap_q ? WAIT_CLEAR : ARMED;
                            invuln <= overlap_q;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    WAIT_CLEAR: begin
                        if (game_over) begin
                            state  <= HALTED;
                            invuln <= 1'b0;
                        end else if (!overlap_q) begin
                            state  <= ARMED;
                            invuln <= 1'b0;
                        end
                    end
                    HALTED: begin
                        if (!game_over) begin
                            state  <= WAIT_CLEAR;
                            invuln <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= ARMED;
                        invuln <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/collision_monitor.md
COLLISION_MONITOR -- requirements
Module: collision_monitor

Interface
REQ-001 The block SHALL have parameter NUM_OBS, default 4, meaning the number of obstacle slots checked.
REQ-002 The block SHALL have parameter PLAYER_Y_TOP, default 200, meaning the first pixel row of the player sprite.
REQ-003 The block SHALL have parameter PLAYER_Y_BOT, default 219, meaning the last pixel row of the player sprite.
REQ-004 The block SHALL have parameter OBST_H, default 16, meaning obstacle height in rows.
REQ-005 The block SHALL have parameter INVULN_CYCLES, default 50_000_000, meaning the grace-period length in clocks; the counter is 26 bits.
REQ-006 The block SHALL have port Clock, input, 1 bit: the single system clock.
REQ-007 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port player_lane, input, 2 bits: the player's current lane, 0-3.
REQ-009 The block SHALL have port obs_valid, input, NUM_OBS bits: per-slot obstacle-active flags.
REQ-010 The block SHALL have port obs_lane, input, 2*NUM_OBS bits: per-slot lane, with slot i at bits [2i+1:2i].
REQ-011 The block SHALL have port obs_y, input, 8*NUM_OBS bits: per-slot top row, with slot i at bits [8i+7:8i].
REQ-012 The block SHALL have port game_over, input, 1 bit: when high, hits are suppressed.
REQ-013 The block SHALL have port clear_score, input, 1 bit: a one-cycle restart pulse.
REQ-014 The block SHALL have port collision, output, 1 bit: a one-cycle hit pulse for the lives handler.
REQ-015 The block SHALL have port invuln, output, 1 bit: high during the grace period, used for sprite blinking.
REQ-016 The block SHALL have port hit_lane, output, 2 bits: the lane of the most recent hit.
REQ-017 The block SHALL have port hit_count, output, 8 bits: the saturating count of hits since restart.

Function
REQ-018 Slot i SHALL overlap when obs_valid[i] is high, obs_lane[i] equals player_lane, obs_y[i]+OBST_H > PLAYER_Y_TOP, and obs_y[i] <= PLAYER_Y_BOT; the addition SHALL be 9-bit with no wrap.
REQ-019 The any-overlap result and the lowest-index overlapping slot's lane SHALL be registered into overlap_q and lane_q (pipeline stage 1).
REQ-020 The FSM states SHALL be ARMED, HIT, GRACE, WAIT_CLEAR and HALTED.
REQ-021 In ARMED, if overlap_q is high and game_over is low, the FSM SHALL go to HIT and latch hit_lane from lane_q.
REQ-022 The collision output SHALL be registered and high for exactly the one cycle the FSM is in HIT; it SHALL rise on the second clock edge after the overlapping inputs are first sampled.
REQ-023 HIT SHALL always go to GRACE, loading the counter with INVULN_CYCLES-1, and SHALL increment hit_count, saturating at 255.
REQ-024 GRACE SHALL decrement the counter each cycle; at zero, it SHALL go to WAIT_CLEAR if overlap_q is high, otherwise to ARMED.
REQ-025 WAIT_CLEAR SHALL go to ARMED on the first cycle in which overlap_q is low, so a lingering obstacle produces no second hit.
REQ-026 invuln SHALL be high in HIT, GRACE and WAIT_CLEAR, and low otherwise.
REQ-027 If game_over is high in any state other than HIT, the FSM SHALL go to HALTED, where collision and invuln are low; when game_over falls, the FSM SHALL go to WAIT_CLEAR.
REQ-028 clear_score SHALL have priority over all transitions: the FSM goes to ARMED, and the counter, hit_count and hit_lane are cleared on the next edge.
REQ-029 There SHALL be at least one low cycle between consecutive collision pulses, so an edge detector downstream sees every hit.
REQ-030 If player_lane changes during GRACE, it SHALL have no effect until the FSM returns to ARMED.

Reset
REQ-031 Asserting Reset SHALL immediately clear overlap_q, lane_q, the counter, hit_count and hit_lane to 0, and set the FSM to ARMED, with collision=0 and invuln=0.
REQ-032 Deassertion of Reset SHALL take effect synchronously with Clock.
REQ-033 Reset asserted mid-GRACE SHALL abort the grace period with no pending pulse.

Structure
REQ-034 Package collision_pkg SHALL hold the FSM state encoding and the default values of PLAYER_Y_TOP, PLAYER_Y_BOT, OBST_H and INVULN_CYCLES.
REQ-035 Sub-module obstacle_overlap SHALL hold the combinational per-slot compare of REQ-018, instantiated NUM_OBS times.
REQ-036 The counter, the FSM and the output registers SHALL reside in collision_monitor.

Verification
REQ-037 The bench SHALL cover: player_lane=2, slot0 valid, lane 2, y=190 -> collision high for one cycle, 2 edges later; hit_lane=2; hit_count=1; invuln=1.
REQ-038 The bench SHALL cover: the same overlap held for INVULN_CYCLES+100 (INVULN_CYCLES=16 in sim) -> exactly one pulse; the FSM stays in WAIT_CLEAR until the overlap drops.
REQ-039 The bench SHALL cover: slot1 (lane 1) and slot3 (lane 1) overlapping together -> one pulse with hit_lane=1; y=220 and y=184 produce no overlap, while y=185 and y=219 do.
REQ-040 The bench SHALL cover: game_over=1 while overlapping -> no pulse and invuln=0; game_over falls while overlap persists -> still no pulse until the overlap clears and re-occurs.
REQ-041 The bench SHALL cover: 300 separated hits -> hit_count saturates at 255; a clear_score pulse mid-GRACE -> ARMED with hit_count=0, and an overlap on the next cycle gives a pulse 2 edges later.
REQ-042 The bench SHALL cover: Reset asserted mid-GRACE -> outputs clear without waiting for a clock edge; no pulse follows release unless a new overlap occurs.
